// File: rtl/ram_pkg.sv
// Shared types and constants for the synchronous RAM with clear engine.
package ram_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_sync_core.sv
// Storage array: one write port and one registered read port, no reset on contents.
module ram_sync_core
  import ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value while re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with valid/ready requests, 1-cycle read response
// and a sequential clear engine that zeroes every word.
module ram_sync_clr
  import ram_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clear_start,
  output logic              busy
);

  localparam int              DEPTH       = depth(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam state_t          RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              ready_reg;
  logic              busy_reg;
  logic              rsp_valid_reg;
  logic              rd_seen_reg;

  logic              accept;
  logic              core_we;
  logic [ADDR_W-1:0] core_waddr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_re;
  logic [DATA_W-1:0] core_rdata;

  assign accept  = req_valid && ready_reg;
  assign core_re = accept && !req_we;

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    core_we      = 1'b0;
    core_waddr   = req_addr;
    core_wdata   = req_wdata;
    case (state_reg)
      CLEAR: begin
        core_we    = 1'b1;
        core_waddr = clr_cnt_reg;
        core_wdata = '0;
        if (clr_cnt_reg == LAST_ADDR) begin
          state_next   = IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      default: begin
        core_we = accept && req_we;
        if (clear_start) begin
          state_next = CLEAR;
        end
      end
    endcase
  end

  // ready/busy are registered from the next state so they are 0/1 during reset
  // and change in the cycle after a state transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= RESET_STATE;
      clr_cnt_reg   <= '0;
      ready_reg     <= 1'b0;
      busy_reg      <= (RESET_STATE == CLEAR);
      rsp_valid_reg <= 1'b0;
      rd_seen_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clr_cnt_reg   <= clr_cnt_next;
      ready_reg     <= (state_next == IDLE);
      busy_reg      <= (state_next == CLEAR);
      rsp_valid_reg <= core_re;
      if (core_re) begin
        rd_seen_reg <= 1'b1;
      end
    end
  end

  ram_sync_core #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_core (
    .clk  (clk),
    .we   (core_we),
    .waddr(core_waddr),
    .wdata(core_wdata),
    .re   (core_re),
    .raddr(req_addr),
    .rdata(core_rdata)
  );

  // The array's read register has no reset; mask it until the first read lands.
  assign rsp_rdata = rd_seen_reg ? core_rdata : '0;
  assign rsp_valid = rsp_valid_reg;
  assign req_ready = ready_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed self-checking bench: 16x8 clear-on-reset instance and 64x32 no-clear instance.
module tb_ram_sync_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: ADDR_W=4, DATA_W=8, CLEAR_ON_RESET=1
  logic       a_reset, a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic       a_clear_start, a_busy;
  logic [3:0] a_req_addr;
  logic [7:0] a_req_wdata, a_rsp_rdata;

  // Instance B: ADDR_W=6, DATA_W=32, CLEAR_ON_RESET=0
  logic        b_reset, b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic        b_clear_start, b_busy;
  logic [5:0]  b_req_addr;
  logic [31:0] b_req_wdata, b_rsp_rdata;

  ram_sync_clr #(.ADDR_W(4), .DATA_W(8), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .reset(a_reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .clear_start(a_clear_start), .busy(a_busy)
  );

  ram_sync_clr #(.ADDR_W(6), .DATA_W(32), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .reset(b_reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .clear_start(b_clear_start), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_wr(input logic [3:0] addr, input logic [7:0] data);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = addr; a_req_wdata = data;
    tick();
    a_req_valid = 1'b0; a_req_we = 1'b0;
    $display("A wr addr=%0d data=%02h", addr, data);
    check("wr_no_rsp", 32'(a_rsp_valid), 32'd0);
  endtask

  task automatic a_rd(input logic [3:0] addr, input logic [7:0] exp);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = addr;
    tick();
    a_req_valid = 1'b0;
    $display("A rd addr=%0d data=%02h", addr, a_rsp_rdata);
    check("rd_vld", 32'(a_rsp_valid), 32'd1);
    check("rd_data", 32'(a_rsp_rdata), 32'(exp));
  endtask

  // Counts cycles busy stays high, bounded so a stuck clear still ends the run.
  task automatic a_busy_len(input string tag);
    int cnt = 0;
    while (a_busy && cnt < 40) begin
      tick();
      cnt++;
    end
    $display("A clear cycles=%0d", cnt);
    check(tag, 32'(cnt), 32'd16);
    check({tag, "_ready"}, 32'(a_req_ready), 32'd1);
  endtask

  initial begin
    a_reset = 1'b1; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0;
    a_req_wdata = '0; a_clear_start = 1'b0;
    b_reset = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0;
    b_req_wdata = '0; b_clear_start = 1'b0;

    tick(); tick();
    check("rst_ready", 32'(a_req_ready), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd1);
    check("rst_vld", 32'(a_rsp_valid), 32'd0);
    check("rst_rdata", 32'(a_rsp_rdata), 32'd0);
    check("b_rst_ready", 32'(b_req_ready), 32'd0);
    check("b_rst_busy", 32'(b_busy), 32'd0);

    // Clear after reset release, then all words read back as zero back-to-back.
    a_reset = 1'b0;
    a_busy_len("por_clear_len");
    for (int i = 0; i < 16; i++) begin
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 4'(i);
      tick();
      $display("A rd addr=%0d data=%02h", i, a_rsp_rdata);
      check("zero_vld", 32'(a_rsp_valid), 32'd1);
      check("zero_data", 32'(a_rsp_rdata), 32'd0);
    end
    a_req_valid = 1'b0;
    tick();

    // Read-after-write
    a_wr(4'd3, 8'hA5);
    a_rd(4'd3, 8'hA5);

    // Back-to-back reads
    a_wr(4'd1, 8'h11);
    a_wr(4'd2, 8'h22);
    a_wr(4'd3, 8'h33);
    a_rd(4'd1, 8'h11);
    a_rd(4'd2, 8'h22);
    a_rd(4'd3, 8'h33);
    tick();
    check("vld_drop", 32'(a_rsp_valid), 32'd0);
    check("rdata_hold", 32'(a_rsp_rdata), 32'h33);

    // clear_start alongside a read: read returns pre-clear data
    a_wr(4'd15, 8'hFF);
    a_clear_start = 1'b1;
    a_rd(4'd15, 8'hFF);
    a_clear_start = 1'b0;
    check("clr_busy", 32'(a_busy), 32'd1);
    check("clr_ready", 32'(a_req_ready), 32'd0);
    a_busy_len("sw_clear_len");
    a_rd(4'd15, 8'h00);

    // Reset in the middle of a clear restarts it from address 0
    a_wr(4'd10, 8'h5A);
    a_rd(4'd10, 8'h5A);
    a_clear_start = 1'b1;
    tick();
    a_clear_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    a_reset = 1'b1;
    #2;
    check("mid_rst_busy", 32'(a_busy), 32'd1);
    check("mid_rst_ready", 32'(a_req_ready), 32'd0);
    tick();
    a_reset = 1'b0;
    a_busy_len("restart_clear_len");
    a_rd(4'd10, 8'h00);

    // Reset while a read response is pending
    a_wr(4'd4, 8'h44);
    a_rd(4'd4, 8'h44);
    a_req_valid = 1'b1; a_req_addr = 4'd4;
    tick();
    a_req_valid = 1'b0;
    a_reset = 1'b1;
    #2;
    check("rdrst_vld", 32'(a_rsp_valid), 32'd0);
    check("rdrst_rdata", 32'(a_rsp_rdata), 32'd0);
    tick();
    a_reset = 1'b0;
    a_busy_len("rdrst_clear_len");

    // No-clear instance, wide data
    b_reset = 1'b0;
    tick();
    check("b_ready", 32'(b_req_ready), 32'd1);
    check("b_busy", 32'(b_busy), 32'd0);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 6'd63; b_req_wdata = 32'hDEADBEEF;
    tick();
    $display("B wr addr=63 data=deadbeef");
    check("b_wr_no_rsp", 32'(b_rsp_valid), 32'd0);
    b_req_we = 1'b0;
    tick();
    b_req_valid = 1'b0;
    $display("B rd addr=63 data=%08h", b_rsp_rdata);
    check("b_rd_vld", 32'(b_rsp_valid), 32'd1);
    check("b_rd_data", b_rsp_rdata, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
